borrow_skip_serial_subtractor: RTL

- Block-serial WIDTH-bit subtractor computing diff = a - b - bin, one BLOCK-bit block per clock.
- Each block uses the block propagate/skip mux on the inter-block borrow chain, computed as a + ~b + ~bin.
- Sits beside the combinational carry-skip adder as its subtract-direction, area-reduced counterpart.
- Uses a valid/ready handshake on both sides. Reports unsigned borrow, signed overflow, zero and the count of skipped blocks.

---
 rtl/borrow_skip_serial_subtractor.sv | 126 ++++++++++++
 1 files changed

// File: rtl/borrow_skip_serial_subtractor.sv
// Block-serial subtractor: diff = a - b - bin, one BLOCK-bit slice per clock,
// with a propagate/skip mux on the inter-block borrow chain (computed as a + ~b + ~bin).
module borrow_skip_serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int BLOCK = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [WIDTH-1:0]                      a,
    input  logic [WIDTH-1:0]                      b,
    input  logic                                  bin,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [WIDTH-1:0]                      diff,
    output logic                                  bout,
    output logic                                  ovf,
    output logic                                  zero,
    output logic [$clog2(WIDTH/BLOCK):0]          skip_cnt
);

    localparam int NBLK = WIDTH / BLOCK;
    localparam int KW   = (NBLK > 1) ? $clog2(NBLK) : 1;
    localparam int CW   = $clog2(NBLK) + 1;
    localparam int MSB  = WIDTH - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  nb_reg;
    logic              carry;
    logic [KW-1:0]     k;

    logic [BLOCK-1:0]  a_blk;
    logic [BLOCK-1:0]  nb_blk;
    logic [BLOCK:0]    blk_sum;
    logic              prop;
    logic              carry_next;
    logic              last_blk;
    logic [WIDTH-1:0]  diff_upd;

    // One slice of the add: when every bit of the block propagates, the incoming
    // carry is passed straight through instead of waiting on the block's ripple.
    always_comb begin
        a_blk      = a_reg[k*BLOCK +: BLOCK];
        nb_blk     = nb_reg[k*BLOCK +: BLOCK];
        blk_sum    = {1'b0, a_blk} + {1'b0, nb_blk} + {{BLOCK{1'b0}}, carry};
        prop       = &(a_blk ^ nb_blk);
        carry_next = prop ? carry : blk_sum[BLOCK];
        last_blk   = (k == KW'(NBLK - 1));
        diff_upd   = diff;
        diff_upd[k*BLOCK +: BLOCK] = blk_sum[BLOCK-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_reg     <= '0;
            nb_reg    <= '0;
            carry     <= 1'b0;
            k         <= '0;
            diff      <= '0;
            bout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            skip_cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        nb_reg   <= ~b;
                        carry    <= ~bin;
                        k        <= '0;
                        diff     <= '0;
                        skip_cnt <= '0;
                        bout     <= 1'b0;
                        ovf      <= 1'b0;
                        zero     <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff  <= diff_upd;
                    carry <= carry_next;
                    if (prop) begin
                        skip_cnt <= skip_cnt + CW'(1);
                    end
                    if (last_blk) begin
                        k         <= '0;
                        out_valid <= 1'b1;
                        // Operands differ in sign exactly when a and ~b share an MSB.
                        bout      <= ~carry_next;
                        ovf       <= (a_reg[MSB] == nb_reg[MSB]) && (diff_upd[MSB] != a_reg[MSB]);
                        zero      <= (diff_upd == '0);
                        state     <= DONE;
                    end else begin
                        k <= k + KW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
